// File: rtl/kws_audio_pkg.sv
// Shared types, constants and the saturation helper for the I2S audio front-end.
package kws_audio_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  // Accumulator width: covers DATA_W up to 32 plus two bits of filter headroom.
  localparam int unsigned ACC_W      = 34;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT_R
  } rx_state_e;

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [ACC_W-1:0] sat_to_dataw(
    input logic signed [ACC_W-1:0] v,
    input int unsigned             w
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (ACC_ONE <<< (w - 1)) - ACC_ONE;
    lo = -hi - ACC_ONE;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/i2s_audio_frontend_if.sv
// Sample bus from the I2S front-end to the keyword-spotting accelerator.
interface i2s_audio_frontend_if
  import kws_audio_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] audio_sample;
  logic              sample_valid;
  logic              frame_start;
  logic              err_short;

  modport master (output audio_sample, sample_valid, frame_start, err_short);
  modport slave  (input  audio_sample, sample_valid, frame_start, err_short);
endinterface

// File: rtl/preemph_filter.sv
// First-order pre-emphasis y = x - a*x_prev with saturation; holds x_prev and the output register.
module preemph_filter
  import kws_audio_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter bit          PREEMPH_EN    = 1'b1,
  parameter int unsigned PREEMPH_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  output logic              out_valid,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0]       x_prev_q;
  logic [DATA_W-1:0]       y_q;
  logic [DATA_W-1:0]       y_d;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] xp_ext;
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    x_ext  = ACC_W'($signed(x));
    xp_ext = ACC_W'($signed(x_prev_q));
    acc    = x_ext - xp_ext + (xp_ext >>> PREEMPH_SHIFT);
    y_d    = PREEMPH_EN ? DATA_W'(sat_to_dataw(acc, DATA_W)) : x;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_prev_q    <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // The output word deliberately survives a clear.
      x_prev_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        x_prev_q <= x;
        y_q      <= y_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: rtl/i2s_audio_frontend.sv
// I2S left-channel receiver: pad synchronisers, word FSM, pre-emphasis and frame counter.
module i2s_audio_frontend
  import kws_audio_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter bit          PREEMPH_EN    = 1'b1,
  parameter int unsigned PREEMPH_SHIFT = 5,
  parameter int unsigned FRAME_LEN     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 i2s_sck,
  input  logic                 i2s_ws,
  input  logic                 i2s_sd,
  i2s_audio_frontend_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [2:0]        sck_q;
  logic [1:0]        ws_q;
  logic [1:0]        sd_q;
  logic              bit_evt;
  logic              ws_s;
  logic              sd_s;
  logic              prev_ws_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cap_req;
  logic              cap_vld_q;
  logic [DATA_W-1:0] x_q;
  logic              err_d, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic              f_valid;
  logic [DATA_W-1:0] f_y;

  assign bit_evt = sck_q[1] & ~sck_q[2];
  assign ws_s    = ws_q[1];
  assign sd_s    = sd_q[1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    cap_req  = 1'b0;
    err_d    = 1'b0;
    if (bit_evt) begin
      unique case (state_q)
        IDLE:   if (!ws_s && prev_ws_q) state_d = SKIP;
        SKIP: begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
        SHIFT: begin
          if (!ws_s) begin
            // Bits past DATA_W (wide slots) are dropped.
            if (bitcnt_q != CNT_W'(DATA_W)) begin
              shreg_d  = {shreg_q[DATA_W-2:0], sd_s};
              bitcnt_d = bitcnt_q + CNT_W'(1);
            end
          end else begin
            if (bitcnt_q == CNT_W'(DATA_W)) cap_req = 1'b1;
            else                            err_d   = 1'b1;
            state_d = WAIT_R;
          end
        end
        WAIT_R: if (!ws_s && prev_ws_q) state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_q     <= '0;
      ws_q      <= '0;
      sd_q      <= '0;
      prev_ws_q <= 1'b0;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      cap_vld_q <= 1'b0;
      x_q       <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      sck_q <= {sck_q[1:0], i2s_sck};
      ws_q  <= {ws_q[0], i2s_ws};
      sd_q  <= {sd_q[0], i2s_sd};
      if (!enable) begin
        prev_ws_q <= 1'b0;
        state_q   <= IDLE;
        bitcnt_q  <= '0;
        shreg_q   <= '0;
        cap_vld_q <= 1'b0;
        x_q       <= '0;
        err_q     <= 1'b0;
        idx_q     <= '0;
      end else begin
        if (bit_evt) prev_ws_q <= ws_s;
        state_q   <= state_d;
        bitcnt_q  <= bitcnt_d;
        shreg_q   <= shreg_d;
        cap_vld_q <= cap_req;
        if (cap_req) x_q <= shreg_q;
        err_q     <= err_d;
        if (f_valid) idx_q <= (idx_q == IDX_W'(FRAME_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  preemph_filter #(
    .DATA_W        (DATA_W),
    .PREEMPH_EN    (PREEMPH_EN),
    .PREEMPH_SHIFT (PREEMPH_SHIFT)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .clear     (~enable),
    .in_valid  (cap_vld_q),
    .x         (x_q),
    .out_valid (f_valid),
    .y         (f_y)
  );

  assign bus.audio_sample = f_y;
  assign bus.sample_valid = f_valid & enable;
  assign bus.frame_start  = f_valid & enable & (idx_q == '0);
  assign bus.err_short    = err_q & enable;

endmodule

// File: doc/i2s_audio_frontend.md
Name: i2s_audio_frontend

Overview:
Upstream audio front-end for cnn_kws_accel. Receives a serial I2S microphone stream (left channel only) and synchronises it into the system clock domain. Applies first-order pre-emphasis with saturation. Delivers one 16-bit signed sample per audio frame on the accelerator's audio_sample/sample_valid interface, plus a frame-boundary marker every FRAME_LEN samples.

Parameters:
DATA_W, 16, output sample width (signed, two's complement)
PREEMPH_EN, 1, 1 = apply pre-emphasis; 0 = pass the raw sample
PREEMPH_SHIFT, 5, coefficient a = 1 - 2^-PREEMPH_SHIFT (0.96875)
FRAME_LEN, 256, samples per analysis frame; must be >= 2

Ports:
clk  input  1  system clock; must be >= 8x i2s_sck frequency
rst  input  1  synchronous, active-low reset
enable  input  1  0 = receiver held idle, all state cleared except outputs
i2s_sck  input  1  I2S bit clock (asynchronous pad)
i2s_ws  input  1  I2S word select; 0 = left, 1 = right (asynchronous pad)
i2s_sd  input  1  I2S serial data, MSB first (asynchronous pad)
audio_sample  output  DATA_W  filtered sample; held until the next sample_valid
sample_valid  output  1  one-clk pulse, audio_sample valid
frame_start  output  1  one-clk pulse coincident with sample_valid of sample index 0
err_short  output  1  one-clk pulse: left word ended with < DATA_W bits

Behaviour:
- Reset (rst=0 at posedge clk): all outputs and registers = 0, FSM = IDLE, x_prev = 0, sample index = 0.
- Synchronisation: sck, ws and sd each pass through a 2-FF synchroniser, plus a third sck stage for edge detection. A bit event is the cycle where synced sck goes 0->1; ws and sd are sampled on that cycle.
- The FSM advances only on bit events:
  - IDLE: wait for a bit event with ws=0 while the previous sampled ws=1 (left word start) -> SKIP. Words already in progress at reset or enable are never captured.
  - SKIP: the I2S one-bit delay slot is ignored -> SHIFT, bitcnt = 0.
  - SHIFT: while ws=0, shift sd into shreg MSB-first. bitcnt saturates at DATA_W, and bits after the DATA_W-th are discarded (32-bit slots are allowed). On ws=1: if bitcnt == DATA_W, raise cap_req; else pulse err_short and raise no cap_req. -> WAIT_R.
  - WAIT_R: right channel ignored; the next ws 1->0 transition -> SKIP.
- Latency: cap_req at cycle N; x = shreg latched at N+1; filtered result registered at N+2 with sample_valid = 1 for exactly one cycle.
- Pre-emphasis, computed in DATA_W+2 signed bits: y = x - x_prev + (x_prev >>> PREEMPH_SHIFT) (arithmetic shift). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. x_prev <= x (raw, unsaturated input) on every capture. With PREEMPH_EN=0, y = x.
- Frame counter: increments on each sample_valid and wraps FRAME_LEN-1 -> 0. frame_start = sample_valid && (index == 0).
- enable=0: FSM -> IDLE, bitcnt, shreg and index cleared, x_prev = 0, in-flight cap_req dropped. audio_sample keeps its last value; pulse outputs are 0.
- Simultaneous rst=0 and enable: reset wins.

Decomposition:
- Package kws_audio_pkg: DATA_W default, FSM state enum (IDLE, SKIP, SHIFT, WAIT_R), saturation-limit constants, and a function sat_to_dataw().
- Sub-module preemph_filter: holds x_prev and the output register. Interface: clk, rst, clear, in_valid, x, out_valid, y. The top holds the synchronisers, FSM, shift register and frame counter.

Test Plan:
- 16-bit left words 0x1000, 0x1000 with PREEMPH_EN=1, SCK = clk/8 -> audio_sample 0x1000 then 0x0080. sample_valid arrives 2 clks after the ws-rise bit event. Right-channel data never appears.
- x_prev = 0x8000, next x = 0x7FFF -> raw result 64511 saturates to audio_sample 0x7FFF. Then x = 0x8000 after x_prev = 0x7FFF -> saturates to 0x8000.
- 32-bit slots carrying 0xABCD1234 -> audio_sample 0xABCD with PREEMPH_EN=0; the lower bits are discarded.
- ws toggles after 10 left bits -> err_short pulses once, no sample_valid. The next full word is captured normally.
- FRAME_LEN=4, 9 words -> frame_start on samples 1, 5 and 9 (indices 0, 4, 8 mod 4) only.
- rst=0 driven for 1 clk mid-SHIFT -> all outputs 0. The partial word is not emitted, and the first capture follows the next ws 1->0 transition. enable=0 for 2 clks mid-word produces identical behaviour, except audio_sample holds its value.
